aes_output_serializer: RTL and testbench
========================================

Name: aes_output_serializer

Overview:
Parametrised output stage for the AES core. It captures each finished cipher/plain block on done_i into a small block FIFO. It then serialises the head block onto a WORD_W-bit bus with a valid/ready handshake, a last-word marker and configurable word order. Unlike the fixed 4-cycle, no-backpressure output buffer, it tolerates a stalled consumer, holds up to DEPTH completed blocks, and flags dropped blocks.

Parameters:
BLOCK_W, 128, block width in bits; must be a multiple of WORD_W.
WORD_W, 32, output word width; N = BLOCK_W/WORD_W words per block (N >= 2).
DEPTH, 2, block FIFO entries; power of two, >= 1.
MSW_FIRST, 0, 0 = emit bits [WORD_W-1:0] first (word 0 = LSW); 1 = emit most-significant word first.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
done_i  in  1  one-cycle pulse: text_in holds a completed block
text_in  in  BLOCK_W  block data, sampled only when done_i=1
blk_ready_o  out  1  1 = FIFO not full; a block offered on done_i will be accepted
text_o  out  WORD_W  current output word
valid_o  out  1  text_o holds a valid word
ready_i  in  1  consumer accepts the word this cycle
last_o  out  1  current word is the final word of its block (valid_o & idx==N-1)
done_o  out  1  one-cycle pulse, registered, in the cycle after the last word of a block transfers
overflow_o  out  1  sticky: a block was offered while the FIFO was full
occ_o  out  $clog2(DEPTH+1)  number of blocks held, including a partially sent head

Behaviour:
- Reset (rst=0, async): wr_ptr, rd_ptr, occ and word index idx all clear. Outputs: valid_o=0, last_o=0, done_o=0, overflow_o=0, text_o=0, blk_ready_o=1, occ_o=0. FIFO storage is not cleared.
- Reset mid-stream discards all held blocks and any partial block. After release, the first valid_o comes only from a new done_i.
- Push: on a clk edge with done_i=1 and occ<DEPTH, text_in is written at wr_ptr and wr_ptr increments (wraps mod DEPTH).
- Overflow: done_i=1 while occ==DEPTH drops the block and sets overflow_o; it stays set until reset. This holds even if a pop happens in the same cycle; there is no same-cycle bypass.
- Handshake: valid_o = (occ!=0). A transfer occurs when valid_o & ready_i.
- While valid_o=1 and ready_i=0, text_o, last_o and idx hold stable.
- valid_o never drops without a transfer, except on reset.
- Word select: word k = text_in bits [k*WORD_W +: WORD_W].
  - MSW_FIRST=0: text_o = word idx of the head entry.
  - MSW_FIRST=1: text_o = word (N-1-idx) of the head entry.
  - text_o = 0 when valid_o=0.
- State machine: two states.
  - EMPTY (occ==0) moves to STREAM on a push.
  - STREAM moves back to EMPTY when the last word of the only held block transfers and no push occurs in the same cycle.
- Transfer, not last: idx increments.
- Transfer with idx==N-1: idx returns to 0, rd_ptr increments (wraps mod DEPTH), and done_o pulses on the next cycle.
- Simultaneous push and pop: occ is unchanged and both pointers advance.
- Latency: done_i sampled at edge t makes valid_o=1 after edge t (first word visible in cycle t+1) if the FIFO was empty.
- With ready_i held at 1, a block drains in N cycles. Back-to-back blocks stream with no idle cycle between them.
- blk_ready_o = (occ<DEPTH), combinational from registered occ.
- text_o, valid_o and last_o are combinational from registered state only. There is no combinational path from ready_i or done_i to any output.

Test Plan:
- Single block, default params, ready_i=1: done_i with 128'h00112233_44556677_8899AABB_CCDDEEFF -> cycles 1..4 give text_o CCDDEEFF, 8899AABB, 44556677, 00112233; last_o=1 on the 4th; done_o pulses in cycle 5; occ_o returns to 0.
- Backpressure: same block with ready_i toggling 1,0,0,1,0,1,1 -> words appear in the same order; text_o holds during stalls; exactly 4 transfers; done_o one pulse.
- Back-to-back plus overflow: three done_i pulses on consecutive cycles with ready_i=0 -> first two accepted, occ_o=2, blk_ready_o=0, overflow_o=1. Raising ready_i then gives 8 words from blocks 1 and 2 only, with no gap between them.
- Push during last-word pop: FIFO full, done_i in the same cycle as a last-word transfer -> block dropped, overflow_o=1, occ_o goes 2→1.
- MSW_FIRST=1, WORD_W=64: block above -> text_o 00112233_44556677 then 8899AABB_CCDDEEFF, last_o on the 2nd word.
- Reset mid-stream: assert rst=0 after the 2nd word -> valid_o=0, occ_o=0, overflow_o=0 immediately. After release, no output until a new done_i; the new block starts at word 0.

Source files
------------

// File: rtl/aes_output_serializer.sv
// AES output stage: queues finished blocks in a small FIFO and streams the
// head block out as WORD_W-bit words over a valid/ready handshake. Blocks
// offered while the FIFO is full are dropped and recorded in a sticky flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_EMPTY  | no block held, valid_o low
// S_STREAM | at least one block held, head block is being presented
module aes_output_serializer #(
   parameter int BLOCK_W   = 128,
   parameter int WORD_W    = 32,
   parameter int DEPTH     = 2,
   parameter bit MSW_FIRST = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         done_i,
   input  logic [BLOCK_W-1:0]           text_in,
   output logic                         blk_ready_o,
   output logic [WORD_W-1:0]            text_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic                         last_o,
   output logic                         done_o,
   output logic                         overflow_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

   localparam int N     = BLOCK_W / WORD_W;
   localparam int IDX_W = $clog2(N);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

   typedef enum logic {S_EMPTY, S_STREAM} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [BLOCK_W-1:0] mem [DEPTH];
   logic [BLOCK_W-1:0] head;
   logic [WORD_W-1:0]  words [N];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [OCC_W-1:0]   occ;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   sel;
   logic               done_q;
   logic               ovf_q;
   logic               push;
   logic               xfer;
   logic               pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Push is decided on registered occupancy only, so a pop in the same
   // cycle never frees a slot for the incoming block.
   assign push = done_i & (occ != OCC_FULL);
   assign xfer = valid_o & ready_i;
   assign pop  = xfer & (idx == IDX_LAST);

   // Block storage; deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= text_in;
   end

   // Pointers, occupancy, word index and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         idx    <= '0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (pop)       idx <= '0;
         else if (xfer) idx <= idx + 1'b1;
         done_q <= pop;
         if (done_i && (occ == OCC_FULL)) ovf_q <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_EMPTY;
      else      state <= state_nxt;
   end

   // Next-state: leave STREAM only when the sole held block finishes.
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY:  if (push) state_nxt = S_STREAM;
         S_STREAM: if (pop && (occ == OCC_ONE) && !push) state_nxt = S_EMPTY;
         default:  state_nxt = S_EMPTY;
      endcase
   end

   // Split the head entry into words.
   assign head = mem[rd_ptr];
   always_comb begin
      for (int k = 0; k < N; k++) words[k] = head[k*WORD_W +: WORD_W];
   end

   // Outputs, from registered state only.
   always_comb begin
      valid_o     = (state == S_STREAM);
      sel         = MSW_FIRST ? (IDX_LAST - idx) : idx;
      text_o      = valid_o ? words[sel] : '0;
      last_o      = valid_o & (idx == IDX_LAST);
      blk_ready_o = (occ != OCC_FULL);
      occ_o       = occ;
      done_o      = done_q;
      overflow_o  = ovf_q;
   end

endmodule

// File: tb/tb_aes_output_serializer.sv
// Directed bench for aes_output_serializer: per-cycle vector table for the
// streaming/backpressure/overflow cases, plus hand-written reset and
// MSW-first sequences.
module tb_aes_output_serializer;

   localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] B2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] B3 = 128'h55555555_66666666_77777777_88888888;

   logic         clk = 1'b0;
   logic         rst;
   logic         done_i;
   logic [127:0] text_in;
   logic         ready_i;

   logic         blk_ready;
   logic [31:0]  text;
   logic         valid;
   logic         last;
   logic         done;
   logic         ovf;
   logic [1:0]   occ;

   logic         blk_ready2;
   logic [63:0]  text2;
   logic         valid2;
   logic         last2;
   logic         done2;
   logic         ovf2;
   logic [1:0]   occ2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aes_output_serializer dut (
      .clk(clk), .rst(rst), .done_i(done_i), .text_in(text_in),
      .blk_ready_o(blk_ready), .text_o(text), .valid_o(valid),
      .ready_i(ready_i), .last_o(last), .done_o(done),
      .overflow_o(ovf), .occ_o(occ)
   );

   aes_output_serializer #(.BLOCK_W(128), .WORD_W(64), .DEPTH(2), .MSW_FIRST(1'b1)) dut_msw (
      .clk(clk), .rst(rst), .done_i(done_i), .text_in(text_in),
      .blk_ready_o(blk_ready2), .text_o(text2), .valid_o(valid2),
      .ready_i(ready_i), .last_o(last2), .done_o(done2),
      .overflow_o(ovf2), .occ_o(occ2)
   );

   typedef struct {
      logic         rst_v;
      logic         dn;
      logic [127:0] din;
      logic         rdy;
      logic         ev;
      logic [31:0]  et;
      logic         el;
      logic         ed;
      logic [1:0]   eo;
      logic         ebr;
      logic         eov;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic r, logic d, logic [127:0] di, logic rd,
                               logic v, logic [31:0] t, logic l, logic dd,
                               logic [1:0] o, logic br, logic ov);
      vec_t x;
      x.rst_v = r;  x.dn = d;  x.din = di; x.rdy = rd;
      x.ev = v;     x.et = t;  x.el = l;   x.ed = dd;
      x.eo = o;     x.ebr = br; x.eov = ov;
      return x;
   endfunction

   task automatic chk(input string nm, input int step, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %h want %h", nm, step, act, exp);
      end
   endtask

   task automatic chk_main(input int step, input logic v, input logic [31:0] t,
                           input logic l, input logic d, input logic [1:0] o,
                           input logic br, input logic ov);
      chk("valid",     step, 128'(valid),     128'(v));
      chk("text",      step, 128'(text),      128'(t));
      chk("last",      step, 128'(last),      128'(l));
      chk("done",      step, 128'(done),      128'(d));
      chk("occ",       step, 128'(occ),       128'(o));
      chk("blk_ready", step, 128'(blk_ready), 128'(br));
      chk("overflow",  step, 128'(ovf),       128'(ov));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // single block, ready held high
      tv.push_back(mk(1,1,B1,1, 1,32'hCCDDEEFF,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h8899AABB,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h44556677,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h00112233,1,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 0,32'h0       ,0,1,2'd0,1,0));
      tv.push_back(mk(1,0,0 ,1, 0,32'h0       ,0,0,2'd0,1,0));
      // backpressure: ready 1,0,0,1,0,1,1
      tv.push_back(mk(1,1,B1,0, 1,32'hCCDDEEFF,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h8899AABB,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,0, 1,32'h8899AABB,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,0, 1,32'h8899AABB,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h44556677,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,0, 1,32'h44556677,0,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h00112233,1,0,2'd1,1,0));
      tv.push_back(mk(1,0,0 ,1, 0,32'h0       ,0,1,2'd0,1,0));
      tv.push_back(mk(1,0,0 ,0, 0,32'h0       ,0,0,2'd0,1,0));
      // three back-to-back offers while stalled, then drain
      tv.push_back(mk(1,1,B1,0, 1,32'hCCDDEEFF,0,0,2'd1,1,0));
      tv.push_back(mk(1,1,B2,0, 1,32'hCCDDEEFF,0,0,2'd2,0,0));
      tv.push_back(mk(1,1,B3,0, 1,32'hCCDDEEFF,0,0,2'd2,0,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h8899AABB,0,0,2'd2,0,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h44556677,0,0,2'd2,0,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h00112233,1,0,2'd2,0,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hD0D1D2D3,0,1,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hC0C1C2C3,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hB0B1B2B3,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hA0A1A2A3,1,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 0,32'h0       ,0,1,2'd0,1,1));
      // reset, fill, then offer during last-word pop of a full FIFO
      tv.push_back(mk(0,0,0 ,0, 0,32'h0       ,0,0,2'd0,1,0));
      tv.push_back(mk(1,1,B1,0, 1,32'hCCDDEEFF,0,0,2'd1,1,0));
      tv.push_back(mk(1,1,B2,0, 1,32'hCCDDEEFF,0,0,2'd2,0,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h8899AABB,0,0,2'd2,0,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h44556677,0,0,2'd2,0,0));
      tv.push_back(mk(1,0,0 ,1, 1,32'h00112233,1,0,2'd2,0,0));
      tv.push_back(mk(1,1,B3,1, 1,32'hD0D1D2D3,0,1,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hC0C1C2C3,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hB0B1B2B3,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hA0A1A2A3,1,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 0,32'h0       ,0,1,2'd0,1,1));
      // push and pop in the same cycle with one block held
      tv.push_back(mk(1,1,B1,0, 1,32'hCCDDEEFF,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h8899AABB,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h44556677,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'h00112233,1,0,2'd1,1,1));
      tv.push_back(mk(1,1,B2,1, 1,32'hD0D1D2D3,0,1,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,0, 1,32'hD0D1D2D3,0,0,2'd1,1,1));
      tv.push_back(mk(1,0,0 ,1, 1,32'hC0C1C2C3,0,0,2'd1,1,1));

      rst = 1'b0; done_i = 1'b0; text_in = '0; ready_i = 1'b0;
      tick();
      tick();
      chk_main(-1, 0, 32'h0, 0, 0, 2'd0, 1, 0);
      rst = 1'b1;

      foreach (tv[i]) begin
         rst     = tv[i].rst_v;
         done_i  = tv[i].dn;
         text_in = tv[i].din;
         ready_i = tv[i].rdy;
         tick();
         chk_main(i, tv[i].ev, tv[i].et, tv[i].el, tv[i].ed, tv[i].eo,
                  tv[i].ebr, tv[i].eov);
      end

      // reset mid-stream: B2 head at word 1, overflow set
      done_i = 1'b0; ready_i = 1'b1;
      tick();
      chk("pre_rst_text", 100, 128'(text), 128'(32'hB0B1B2B3));
      rst = 1'b0;
      #1;
      chk_main(101, 0, 32'h0, 0, 0, 2'd0, 1, 0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_valid", 110 + c, 128'(valid), 128'(1'b0));
      end
      done_i = 1'b1; text_in = B1;
      tick();
      done_i = 1'b0; text_in = '0;
      chk_main(120, 1, 32'hCCDDEEFF, 0, 0, 2'd1, 1, 0);

      // MSW-first 64-bit instance
      rst = 1'b0; ready_i = 1'b0;
      tick();
      rst = 1'b1;
      done_i = 1'b1; text_in = B1;
      tick();
      done_i = 1'b0; text_in = '0;
      chk("msw_valid0", 200, 128'(valid2), 128'(1'b1));
      chk("msw_text0",  200, 128'(text2),  128'(64'h00112233_44556677));
      chk("msw_last0",  200, 128'(last2),  128'(1'b0));
      ready_i = 1'b1;
      tick();
      chk("msw_text1",  201, 128'(text2),  128'(64'h8899AABB_CCDDEEFF));
      chk("msw_last1",  201, 128'(last2),  128'(1'b1));
      tick();
      chk("msw_valid2", 202, 128'(valid2), 128'(1'b0));
      chk("msw_done",   202, 128'(done2),  128'(1'b1));
      chk("msw_occ",    202, 128'(occ2),   128'(2'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
